// File: rtl/obc_bitslice_serializer.sv
//==============================================================================
// Module      : obc_bitslice_serializer
// Description : Front end of the OBC distributed-arithmetic 16-point DFT.
//               Accepts one frame of 16 parallel two's-complement samples and
//               emits it as DATA_W bit-slices, LSB first, one per handshake.
//               Each 16-bit slice addresses the OBC coefficient ROMs.
//               slice_first lets the shift-accumulator clear.
//               slice_last marks the sign-bit slice.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   DATA_W       sample width; also the number of slices per frame (>=2)
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     frame present on samples_in
//   in_ready     serializer can accept a frame this cycle
//   samples_in   sample k at [k*DATA_W +: DATA_W], k = 0..15
//   slice_valid  slice_out holds a valid bit-slice
//   slice_ready  downstream accepts the slice this cycle
//   slice_out    slice_out[k] = current bit of sample k
//   slice_idx    bit position of the current slice
//   slice_first  slice_idx == 0 (accumulator clear)
//   slice_last   slice_idx == DATA_W-1 (sign-bit slice)
//   busy         frame in progress
//   sel_out      ROM select word, sel_out[j] = slice_out[2j] ^ slice_out[2j+1]
//                (present only when OBC_SEL_EN is defined)
// Configuration macro
//   OBC_SEL_EN   adds the registered sel_out port
//==============================================================================
`default_nettype none

module obc_bitslice_serializer #(
  parameter int DATA_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [16*DATA_W-1:0]       samples_in,
  output logic                       slice_valid,
  input  logic                       slice_ready,
  output logic [15:0]                slice_out,
  output logic [$clog2(DATA_W)-1:0]  slice_idx,
  output logic                       slice_first,
  output logic                       slice_last,
  output logic                       busy
`ifdef OBC_SEL_EN
  ,
  output logic [7:0]                 sel_out
`endif
);

  localparam int                IDX_W  = $clog2(DATA_W);
  localparam logic [IDX_W-1:0]  C_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  logic [DATA_W-1:0]  r_sh [16];
  logic [IDX_W-1:0]   r_idx;
  logic               r_valid;

  logic               w_last;
  logic               w_hs;
  logic               w_accept;
  logic               w_in_ready;
  logic               w_do_shift;
  logic               w_do_stop;
  logic [15:0]        w_cur_lsb;
  logic [15:0]        w_load_lsb;
  logic [15:0]        w_shift_lsb;

  // Bit-slice gathering: current slice, the slice a freshly loaded frame
  // presents first, and the slice that appears after the next shift.
  always_comb begin
    w_cur_lsb   = '0;
    w_load_lsb  = '0;
    w_shift_lsb = '0;
    for (int k = 0; k < 16; k++) begin
      w_cur_lsb[k]   = r_sh[k][0];
      w_load_lsb[k]  = samples_in[k*DATA_W];
      w_shift_lsb[k] = r_sh[k][1];
    end
  end

  assign w_last = (r_idx == C_LAST);
  assign w_hs   = r_valid & slice_ready;

  // A new frame may only be taken on the last slice when that slice is also
  // being consumed; otherwise the sign slice would be overwritten.
  assign w_in_ready = (r_state == S_IDLE) | (r_valid & w_last & slice_ready);
  assign w_accept   = in_valid & w_in_ready;
  assign w_do_shift = w_hs & ~w_last;
  assign w_do_stop  = w_hs & w_last & ~w_accept;

`ifdef OBC_SEL_EN
  logic [7:0] r_sel;

  function automatic logic [7:0] f_sel(input logic [15:0] s);
    logic [7:0] v;
    v = '0;
    for (int j = 0; j < 8; j++) begin
      v[j] = s[2*j] ^ s[2*j+1];
    end
    return v;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_idx   <= '0;
      for (int k = 0; k < 16; k++) begin
        r_sh[k] <= '0;
      end
`ifdef OBC_SEL_EN
      r_sel   <= '0;
`endif
    end else begin
      if (w_accept) begin
        // Load (also covers the zero-bubble hand-over on the last slice).
        r_state <= S_SHIFT;
        r_valid <= 1'b1;
        r_idx   <= '0;
        for (int k = 0; k < 16; k++) begin
          r_sh[k] <= samples_in[k*DATA_W +: DATA_W];
        end
`ifdef OBC_SEL_EN
        r_sel   <= f_sel(w_load_lsb);
`endif
      end else if (w_do_shift) begin
        r_idx <= r_idx + 1'b1;
        for (int k = 0; k < 16; k++) begin
          r_sh[k] <= {1'b0, r_sh[k][DATA_W-1:1]};
        end
`ifdef OBC_SEL_EN
        r_sel <= f_sel(w_shift_lsb);
`endif
      end else if (w_do_stop) begin
        r_state <= S_IDLE;
        r_valid <= 1'b0;
        r_idx   <= '0;
`ifdef OBC_SEL_EN
        r_sel   <= '0;
`endif
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign slice_valid = r_valid;
  // Gated so stale shift-register contents never appear while idle.
  assign slice_out   = r_valid ? w_cur_lsb : 16'h0000;
  assign slice_idx   = r_idx;
  assign slice_first = r_valid & (r_idx == '0);
  assign slice_last  = r_valid & w_last;
  assign busy        = (r_state == S_SHIFT);
`ifdef OBC_SEL_EN
  assign sel_out     = r_sel;
`endif

endmodule

`default_nettype wire

// File: tb/tb_obc_bitslice_serializer.sv
//==============================================================================
// Module      : tb_obc_bitslice_serializer
// Description : Self-checking bench for obc_bitslice_serializer (DATA_W=16).
//               Expected slices are queued when a frame is accepted and
//               compared as the DUT hands each slice off.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_obc_bitslice_serializer;

  localparam int DW = 16;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [16*DW-1:0] samples_in;
  logic            slice_valid;
  logic            slice_ready;
  logic [15:0]     slice_out;
  logic [3:0]      slice_idx;
  logic            slice_first;
  logic            slice_last;
  logic            busy;
`ifdef OBC_SEL_EN
  logic [7:0]      sel_out;
`endif

  obc_bitslice_serializer #(.DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .samples_in  (samples_in),
    .slice_valid (slice_valid),
    .slice_ready (slice_ready),
    .slice_out   (slice_out),
    .slice_idx   (slice_idx),
    .slice_first (slice_first),
    .slice_last  (slice_last),
    .busy        (busy)
`ifdef OBC_SEL_EN
    ,
    .sel_out     (sel_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] s;
    logic [3:0]  idx;
    logic        first;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   run = 0;
  int   max_run = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sel_of(input logic [15:0] s);
    logic [7:0] v;
    v = '0;
    for (int j = 0; j < 8; j++) v[j] = s[2*j] ^ s[2*j+1];
    return v;
  endfunction

  // Queue the 16 expected slices of a frame.
  task automatic push_frame(input logic [16*DW-1:0] f);
    exp_t e;
    for (int b = 0; b < DW; b++) begin
      for (int k = 0; k < 16; k++) e.s[k] = f[k*DW + b];
      e.idx   = 4'(b);
      e.first = (b == 0);
      e.last  = (b == DW - 1);
      q.push_back(e);
    end
  endtask

  // Monitor: compare every slice handshake against the scoreboard head.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (slice_valid) run++;
    else begin
      if (run > max_run) max_run = run;
      run = 0;
    end
    if (rst_n && slice_valid && slice_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_slice", 32'(slice_idx), 32'hFFFF_FFFF);
      end else begin
        e = q.pop_front();
        chk("slice_out",   32'(slice_out),   32'(e.s));
        chk("slice_idx",   32'(slice_idx),   32'(e.idx));
        chk("slice_first", 32'(slice_first), 32'(e.first));
        chk("slice_last",  32'(slice_last),  32'(e.last));
`ifdef OBC_SEL_EN
        chk("sel_out",     32'(sel_out),     32'(sel_of(e.s)));
`endif
      end
    end
  end

  // Called at a falling edge; returns at a falling edge after acceptance.
  task automatic send_frame(input logic [16*DW-1:0] f);
    bit done;
    done       = 1'b0;
    in_valid   = 1'b1;
    samples_in = f;
    for (int t = 0; t < 200 && !done; t++) begin
      #1;
      if (in_ready) begin
        push_frame(f);
        done = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain_and_idle(input int exp_run);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 300 && !done; t++) begin
      @(negedge clk);
      #3;
      if (q.size() == 0) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 32'(q.size()), 32'd0);
    @(negedge clk);
    #3;
    chk("idle_valid", 32'(slice_valid), 32'd0);
    chk("idle_busy",  32'(busy),        32'd0);
    chk("idle_ready", 32'(in_ready),    32'd1);
    if (exp_run > 0) chk("valid_run", 32'(max_run), 32'(exp_run));
  endtask

  task automatic wait_idx(input logic [3:0] idx);
    bit done;
    done = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      #1;
      if (slice_valid && slice_idx == idx) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) chk("idx_timeout", 32'(slice_idx), 32'(idx));
  endtask

  logic [16*DW-1:0] f_ramp, f_sign, f_s0;

  initial begin
    for (int k = 0; k < 16; k++) begin
      f_ramp[k*DW +: DW] = 16'(k);
      f_sign[k*DW +: DW] = 16'h8000;
      f_s0[k*DW +: DW]   = (k == 0) ? 16'hFFFF : 16'h0000;
    end
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    slice_ready = 1'b1;
    samples_in  = '0;

    // 1. Reset / idle
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 32'(slice_valid), 32'd0);
    chk("rst_slice", 32'(slice_out),   32'h0000);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_ready", 32'(in_ready),    32'd1);
    chk("rst_idx",   32'(slice_idx),   32'd0);
    chk("rst_flags", 32'({slice_first, slice_last}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rel_valid", 32'(slice_valid), 32'd0);
    chk("rel_ready", 32'(in_ready),    32'd1);
    @(negedge clk);

    // 2. Ramp frame
    max_run = 0;
    send_frame(f_ramp);
    drain_and_idle(16);

    // 3. Sign slice frames
    @(negedge clk);
    send_frame(f_sign);
    drain_and_idle(16);
    @(negedge clk);
    send_frame(f_s0);
    drain_and_idle(16);

    // 4. Backpressure at slice 5
    @(negedge clk);
    max_run = 0;
    send_frame(f_ramp);
    wait_idx(4'd5);
    slice_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("stall_idx",   32'(slice_idx),   32'd5);
      chk("stall_slice", 32'(slice_out),   32'h0000);
      chk("stall_valid", 32'(slice_valid), 32'd1);
    end
    @(negedge clk);
    slice_ready = 1'b1;
    drain_and_idle(0);

    // 5. Back-to-back frames
    @(negedge clk);
    max_run = 0;
    send_frame(f_ramp);
    send_frame(f_sign);
    drain_and_idle(32);

    // 6. Reset mid-frame at slice 7
    @(negedge clk);
    send_frame(f_ramp);
    wait_idx(4'd7);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(slice_valid), 32'd0);
    chk("midrst_slice", 32'(slice_out),   32'h0000);
    chk("midrst_busy",  32'(busy),        32'd0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_valid", 32'(slice_valid), 32'd0);
    chk("post_idx",   32'(slice_idx),   32'd0);
    chk("post_slice", 32'(slice_out),   32'h0000);
    @(negedge clk);
    max_run = 0;
    send_frame(f_s0);
    drain_and_idle(16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
